// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage feeding the IF/ID register.
// Owns the PC, fetches one word at a time over a req/ack handshake and
// presents the fetched instruction (or a NOP bubble) with its PC+4.
// Optional fetch watchdog: define IF_FETCH_TIMEOUT_EN to compile it in.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] ir_out,
  output logic        ir_valid,
  output logic        addr_err,
  output logic        fetch_err
);

  // BACKOFF is the one-cycle request gap after a watchdog expiry.
  typedef enum logic [1:0] {IDLE, REQ, PRESENT, BACKOFF} state_t;

  // Reject out-of-range watchdog limits at elaboration.
  if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 255) begin : g_bad_timeout
    $error("if_fetch_unit: TIMEOUT_CYC must be in 2..255");
  end

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic        addr_err_q, addr_err_d;

`ifdef IF_FETCH_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);
  logic [7:0] cnt_q, cnt_d;
  logic       fetch_err_q, fetch_err_d;
`endif

  // Next-state, PC and buffer update; redirect overrides everything but IDLE.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    buf_d      = buf_q;
    buf_pc_d   = buf_pc_q;
    addr_err_d = addr_err_q;
`ifdef IF_FETCH_TIMEOUT_EN
    cnt_d       = 8'd0;  // cleared on every state entry; only a waiting REQ counts
    fetch_err_d = fetch_err_q;
`endif
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (imem_ack) begin
          buf_d    = imem_rdata;
          buf_pc_d = pc_q;
          state_d  = PRESENT;
        end else begin
`ifdef IF_FETCH_TIMEOUT_EN
          if (cnt_q == TMO_LAST) begin
            fetch_err_d = 1'b1;
            state_d     = BACKOFF;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
`endif
        end
      end
      PRESENT: begin
        // Without stall the IF/ID register captures this edge.
        if (!stall) begin
          pc_d    = pc_q + 32'd4;
          state_d = REQ;
        end
      end
      BACKOFF: state_d = REQ;  // re-issue the same pc
      default: state_d = IDLE;
    endcase

    if (redirect && state_q != IDLE) begin
      pc_d     = {redirect_pc[31:2], 2'b00};
      state_d  = REQ;
      buf_d    = 32'h0;
      buf_pc_d = 32'h0;
`ifdef IF_FETCH_TIMEOUT_EN
      cnt_d = 8'd0;
`endif
      if (redirect_pc[1:0] != 2'b00) addr_err_d = 1'b1;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      buf_q      <= 32'h0;
      buf_pc_q   <= 32'h0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      buf_q      <= buf_d;
      buf_pc_q   <= buf_pc_d;
      addr_err_q <= addr_err_d;
    end
  end

`ifdef IF_FETCH_TIMEOUT_EN
  // Watchdog counter and sticky expiry flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= 8'd0;
      fetch_err_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      fetch_err_q <= fetch_err_d;
    end
  end
  assign fetch_err = fetch_err_q;
`else
  assign fetch_err = 1'b0;
`endif

  // Outputs decoded from state and buffer only.
  always_comb begin
    imem_req  = (state_q == REQ);
    imem_addr = pc_q;
    ir_valid  = (state_q == PRESENT);
    ir_out    = (state_q == PRESENT) ? buf_q : 32'h0;
    pc_out    = (state_q == PRESENT) ? (buf_pc_q + 32'd4) : 32'h0;
    addr_err  = addr_err_q;
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed scenarios plus a randomized run checked
// against a program-order model of which instruction must appear next.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc_out;
  logic [31:0] ir_out;
  logic        ir_valid;
  logic        addr_err;
  logic        fetch_err;

  int total = 0;
  int bad   = 0;

  if_fetch_unit #(.RESET_PC(32'h0), .TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .pc_out(pc_out),
    .ir_out(ir_out), .ir_valid(ir_valid), .addr_err(addr_err),
    .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  // Instruction memory contents as a pure function of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0;
    tick(); tick();
    total++;
    if (imem_req !== 1'b0 || ir_valid !== 1'b0 || ir_out !== 32'h0 || pc_out !== 32'h0 ||
        addr_err !== 1'b0 || fetch_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: req=%b valid=%b ir=%h pc=%h aerr=%b ferr=%b required all zero",
               imem_req, ir_valid, ir_out, pc_out, addr_err, fetch_err);
    end
    rst = 1'b0;
    #1;
    total++;
    if (imem_req !== 1'b0) begin
      bad++; $display("FAIL idle_cycle: req=%b required 0", imem_req);
    end
    tick();
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      bad++; $display("FAIL first_req: req=%b addr=%h required 1/00000000", imem_req, imem_addr);
    end
    imem_ack = 1'b1; imem_rdata = 32'h2008_0005;
    tick();
    imem_ack = 1'b0;
    total++;
    if (ir_valid !== 1'b1 || ir_out !== 32'h2008_0005 || pc_out !== 32'h4 || imem_req !== 1'b0) begin
      bad++;
      $display("FAIL first_present: valid=%b ir=%h pc=%h req=%b required 1/20080005/00000004/0",
               ir_valid, ir_out, pc_out, imem_req);
    end
    $display("reset: first fetch ir=%h pc_out=%h", ir_out, pc_out);
    tick();
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin
      bad++; $display("FAIL second_req: req=%b addr=%h required 1/00000004", imem_req, imem_addr);
    end
  endtask

  task automatic test_stall();
    imem_ack = 1'b1; imem_rdata = mem_word(32'h4);
    tick();
    imem_ack = 1'b0; stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if (ir_valid !== 1'b1 || ir_out !== mem_word(32'h4) || pc_out !== 32'h8 || imem_req !== 1'b0) begin
        bad++;
        $display("FAIL stall_hold[%0d]: valid=%b ir=%h pc=%h req=%b required 1/%h/00000008/0",
                 k, ir_valid, ir_out, pc_out, imem_req, mem_word(32'h4));
      end
    end
    stall = 1'b0;
    tick();
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h8 || ir_valid !== 1'b0) begin
      bad++; $display("FAIL stall_release: req=%b addr=%h valid=%b required 1/00000008/0",
                      imem_req, imem_addr, ir_valid);
    end
    $display("stall: held 3 cycles, next addr=%h", imem_addr);
  endtask

  task automatic test_redirect_ack();
    imem_ack = 1'b1; imem_rdata = mem_word(32'h8);
    redirect = 1'b1; redirect_pc = 32'h40;
    tick();
    imem_ack = 1'b0; redirect = 1'b0;
    total++;
    if (ir_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h40 || addr_err !== 1'b0) begin
      bad++; $display("FAIL redirect_ack: valid=%b req=%b addr=%h aerr=%b required 0/1/00000040/0",
                      ir_valid, imem_req, imem_addr, addr_err);
    end
    $display("redirect with ack: addr=%h valid=%b", imem_addr, ir_valid);
  endtask

  task automatic test_misaligned();
    redirect = 1'b1; redirect_pc = 32'h43;
    tick();
    redirect = 1'b0;
    total++;
    if (imem_addr !== 32'h40 || addr_err !== 1'b1) begin
      bad++; $display("FAIL misaligned: addr=%h aerr=%b required 00000040/1", imem_addr, addr_err);
    end
    imem_ack = 1'b1; imem_rdata = mem_word(32'h40);
    tick();
    imem_ack = 1'b0;
    total++;
    if (ir_out !== mem_word(32'h40) || pc_out !== 32'h44 || addr_err !== 1'b1) begin
      bad++; $display("FAIL misaligned_fetch: ir=%h pc=%h aerr=%b required %h/00000044/1",
                      ir_out, pc_out, addr_err, mem_word(32'h40));
    end
    tick();
    $display("misaligned redirect: addr_err=%b", addr_err);
  endtask

  task automatic test_reset_stale();
    // Currently in REQ at 0x44; reset asynchronously mid-cycle.
    rst = 1'b1;
    #2;
    total++;
    if (imem_req !== 1'b0 || addr_err !== 1'b0 || ir_valid !== 1'b0) begin
      bad++; $display("FAIL async_reset: req=%b aerr=%b valid=%b required 0/0/0",
                      imem_req, addr_err, ir_valid);
    end
    tick();
    rst = 1'b0;
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;  // stale response during IDLE
    tick();
    imem_ack = 1'b0;
    total++;
    if (ir_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      bad++; $display("FAIL stale_ack: valid=%b req=%b addr=%h required 0/1/00000000",
                      ir_valid, imem_req, imem_addr);
    end
    imem_ack = 1'b1; imem_rdata = mem_word(32'h0);
    tick();
    imem_ack = 1'b0;
    total++;
    if (ir_out !== mem_word(32'h0) || pc_out !== 32'h4) begin
      bad++; $display("FAIL post_reset_fetch: ir=%h pc=%h required %h/00000004",
                      ir_out, pc_out, mem_word(32'h0));
    end
    tick();  // now REQ at 4
    $display("reset mid-REQ: stale ack ignored, refetch from 0");
  endtask

  task automatic test_random();
    logic [31:0] exp_pc = 32'h4;
    logic        exp_aerr = 1'b0;
    logic        last_redir = 1'b0;
    int          lat = 0;
    int          waited = 0;
    int          presented = 0;
    for (int i = 0; i < 500; i++) begin
      logic        redir;
      logic [31:0] tgt;
      if (ir_valid === 1'b1) begin
        total++;
        presented++;
        if (ir_out !== mem_word(exp_pc) || pc_out !== exp_pc + 32'd4 || imem_req !== 1'b0) begin
          bad++; $display("FAIL rnd_present[%0d]: ir=%h pc=%h req=%b required %h/%h/0",
                          i, ir_out, pc_out, imem_req, mem_word(exp_pc), exp_pc + 32'd4);
        end
      end else begin
        total++;
        if (ir_out !== 32'h0 || pc_out !== 32'h0) begin
          bad++; $display("FAIL rnd_bubble[%0d]: ir=%h pc=%h required 0/0", i, ir_out, pc_out);
        end
      end
      if (imem_req === 1'b1) begin
        total++;
        if (imem_addr !== exp_pc) begin
          bad++; $display("FAIL rnd_addr[%0d]: addr=%h required %h", i, imem_addr, exp_pc);
        end
      end
      total++;
      if (addr_err !== exp_aerr || fetch_err !== 1'b0) begin
        bad++; $display("FAIL rnd_flags[%0d]: aerr=%b ferr=%b required %b/0",
                        i, addr_err, fetch_err, exp_aerr);
      end
      if (last_redir) begin
        total++;
        if (ir_valid !== 1'b0) begin
          bad++; $display("FAIL rnd_redirect_bubble[%0d]: valid=%b required 0", i, ir_valid);
        end
      end
      // Choose the next cycle's inputs.
      redir = ($urandom_range(0, 11) == 0);
      tgt   = $urandom & 32'h0000_0FFF;
      redirect = redir; redirect_pc = tgt;
      stall = ($urandom_range(0, 2) == 0);
      if (imem_req === 1'b1 && waited >= lat) begin
        imem_ack = 1'b1; imem_rdata = mem_word(imem_addr);
        waited = 0; lat = $urandom_range(0, 2);
      end else begin
        imem_ack = (imem_req !== 1'b1) && ($urandom_range(0, 7) == 0);  // stray ack
        imem_rdata = $urandom;
        if (imem_req === 1'b1) waited++;
      end
      if (redir) begin
        exp_pc = tgt & 32'hFFFF_FFFC;
        exp_aerr = exp_aerr | (tgt[1:0] != 2'b00);
        waited = 0;
      end else if (ir_valid === 1'b1 && !stall) begin
        exp_pc = exp_pc + 32'd4;
      end
      last_redir = redir;
      tick();
    end
    redirect = 1'b0; stall = 1'b0; imem_ack = 1'b0;
    $display("random: %0d instructions presented", presented);
  endtask

  task automatic test_timeout();
    redirect = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect = 1'b0; stall = 1'b0; imem_ack = 1'b0;
`ifdef IF_FETCH_TIMEOUT_EN
    for (int k = 0; k < 4; k++) begin
      total++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h100 || fetch_err !== 1'b0) begin
        bad++; $display("FAIL tmo_wait[%0d]: req=%b addr=%h ferr=%b required 1/00000100/0",
                        k, imem_req, imem_addr, fetch_err);
      end
      if (k < 3) tick();
    end
    tick();
    total++;
    if (imem_req !== 1'b0 || fetch_err !== 1'b1) begin
      bad++; $display("FAIL tmo_expire: req=%b ferr=%b required 0/1", imem_req, fetch_err);
    end
    tick();
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100 || fetch_err !== 1'b1) begin
      bad++; $display("FAIL tmo_reissue: req=%b addr=%h ferr=%b required 1/00000100/1",
                      imem_req, imem_addr, fetch_err);
    end
`else
    for (int k = 0; k < 20; k++) begin
      total++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h100 || fetch_err !== 1'b0) begin
        bad++; $display("FAIL no_tmo[%0d]: req=%b addr=%h ferr=%b required 1/00000100/0",
                        k, imem_req, imem_addr, fetch_err);
      end
      tick();
    end
`endif
    imem_ack = 1'b1; imem_rdata = mem_word(32'h100);
    tick();
    imem_ack = 1'b0;
    total++;
    if (ir_valid !== 1'b1 || ir_out !== mem_word(32'h100) || pc_out !== 32'h104) begin
      bad++; $display("FAIL tmo_fetch: valid=%b ir=%h pc=%h required 1/%h/00000104",
                      ir_valid, ir_out, pc_out, mem_word(32'h100));
    end
    $display("watchdog scenario: fetch_err=%b", fetch_err);
  endtask

  initial begin
    test_reset();
    test_stall();
    test_redirect_ack();
    test_misaligned();
    test_reset_stale();
    test_random();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch stage directly upstream of the IF/ID pipeline register. Owns the PC and issues word reads to instruction memory over a req/ack handshake. Presents each fetched instruction and its PC+4 on pc_out/ir_out, which feed the IF/ID pcin/irin inputs. Presents a NOP (32'h0) bubble whenever no instruction is ready. Honours the shared hazard stall and accepts branch/jump redirects from the ID stage.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
TIMEOUT_CYC, 16, fetch watchdog limit in cycles; used only when the optional feature is compiled in; legal range 2..255.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous, active-high reset.
stall  input  1  hazard stall; the same signal drives the IF/ID stall input.
redirect  input  1  single-cycle pulse; load redirect_pc as the new fetch PC.
redirect_pc  input  32  branch/jump target.
imem_req  output  1  read request, held until ack.
imem_addr  output  32  word address; bits [1:0] are always 0.
imem_ack  input  1  read data valid this cycle.
imem_rdata  input  32  instruction word.
pc_out  output  32  PC+4 of the presented instruction; 0 when ir_valid=0.
ir_out  output  32  presented instruction; 32'h0 (NOP) when ir_valid=0.
ir_valid  output  1  ir_out/pc_out hold a real instruction.
addr_err  output  1  sticky flag: a misaligned redirect_pc was received.
fetch_err  output  1  sticky flag: watchdog expired (optional feature only; tied to 0 otherwise).

Behaviour:
- Reset (async, any state):
  - pc=RESET_PC, state=IDLE.
  - imem_req=0, ir_valid=0, ir_out=0, pc_out=0, addr_err=0, fetch_err=0, internal buffer cleared.
- FSM states:
  - IDLE: imem_req=0; next state REQ unconditionally. Exactly 1 cycle after rst deasserts.
  - REQ: imem_req=1, imem_addr=pc.
    - imem_ack=1 and redirect=0: buf<=imem_rdata, buf_pc<=pc; go to PRESENT.
  - PRESENT: imem_req=0, ir_valid=1, ir_out=buf, pc_out=buf_pc+4.
    - stall=0: IF/ID captures at this edge; pc<=pc+4 (32-bit wrap, no flag); go to REQ.
    - stall=1: hold every output and the pc.
- Redirect (any state except IDLE) has highest priority after reset, including over stall and over a same-cycle ack:
  - pc<=redirect_pc with bits[1:0] forced to 0; go to REQ.
  - Buffer dropped, so ir_valid=0 from the next cycle.
  - Same-cycle imem_rdata is discarded.
  - If redirect_pc[1:0]!=0, set addr_err (cleared only by rst).
  - Redirect in IDLE is ignored.
- imem_ack outside REQ is ignored (stale response after reset or redirect).
- Memory contract: one outstanding request maximum; memory must not ack a request after imem_req drops.
- Throughput: minimum 2 cycles per instruction (REQ with immediate ack, then PRESENT). Ack latency adds cycles in REQ.
- Outputs are registered or decoded from state/buffer only; no combinational path from any input to any output.

Optional Feature:
Macro IF_FETCH_TIMEOUT_EN.
- Defined:
  - An 8-bit counter runs in REQ and clears on state entry.
  - When it reaches TIMEOUT_CYC with no ack: set fetch_err (sticky until rst), drop imem_req for 1 cycle, then re-issue the same pc.
  - Redirect clears the counter.
- Undefined:
  - No counter; REQ waits indefinitely.
  - fetch_err is constant 0.

Test Plan:
1. Reset release with RESET_PC=0, memory acks in 1 cycle returning 0x20080005 at addr 0 -> imem_req rises at cycle 2; ir_out=0x20080005, pc_out=4, ir_valid=1 at cycle 3; next imem_addr=4.
2. stall=1 for 3 cycles while in PRESENT -> ir_out, pc_out, pc and imem_req=0 all unchanged; after stall drops, next imem_addr=pc+4.
3. redirect=1, redirect_pc=0x40 in the same cycle as an ack of addr 8 -> rdata discarded; next cycle ir_valid=0, imem_addr=0x40.
4. redirect_pc=0x43 -> imem_addr=0x40; addr_err=1 and stays 1 until rst.
5. rst pulse asserted mid-REQ, then a stale ack 1 cycle after release -> ack ignored; first fetch is at RESET_PC.
6. With IF_FETCH_TIMEOUT_EN, TIMEOUT_CYC=4, no ack -> fetch_err=1 after 4 REQ cycles, req low for 1 cycle, then re-request of the same address.
